// File: rtl/symbol_fifo.sv
// symbol_fifo: circular buffer of 2-bit symbols that feeds a free-running
// sequence detector. When no symbol is popped it drives the idle symbol 0,
// which returns the detector to its start state. It also reports occupancy
// and a sticky flag for symbols dropped while full.
module symbol_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        in_num,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic [1:0]        num,
    output logic              num_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              drop_err
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    // Symbol storage. It has no reset because its contents are don't-care
    // until they are written.
    logic [1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        num_q, num_d;
    logic              num_valid_q, num_valid_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              drop_err_q, drop_err_d;

    logic push;
    logic pop;

    // Handshakes use only registered state. A pop in the same cycle does not
    // free a slot for a push while the buffer is full.
    always_comb begin
        push = in_valid && !full_q;
        pop  = out_ready && !empty_q;
    end

    // Next-state logic. When there is no pop, num is forced to the idle symbol.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        num_d       = 2'b00;
        num_valid_d = 1'b0;
        drop_err_d  = drop_err_q;

        if (push) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rptr_d      = rptr_q + ADDR_W'(1);
            num_d       = mem[rptr_q];
            num_valid_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (in_valid && full_q) begin
            drop_err_d = 1'b1;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    // Control and output registers. Reset clears them asynchronously, so num
    // returns to idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            num_q       <= 2'b00;
            num_valid_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            drop_err_q  <= drop_err_d;
        end
    end

    // Storage write port. A symbol is written only when the push is accepted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= in_num;
        end
    end

    assign in_ready  = !full_q;
    assign num       = num_q;
    assign num_valid = num_valid_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_symbol_fifo.sv
// Testbench for symbol_fifo. It compares the DUT against a queue-based
// reference model and a small 1-2-3 pattern watcher on num.
module tb_symbol_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        in_num;
    logic              in_valid;
    logic              in_ready;
    logic              out_ready;
    logic [1:0]        num;
    logic              num_valid;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              drop_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [1:0] mq [$];
    logic [1:0] m_num;
    logic       m_valid;
    logic       m_drop;

    // Pattern watcher for the detector that consumes num.
    logic [5:0] hist;
    logic       det_seen;

    logic [10:0] obs;
    logic [10:0] expv;

    symbol_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_num(in_num), .in_valid(in_valid),
        .in_ready(in_ready), .out_ready(out_ready), .num(num),
        .num_valid(num_valid), .count(count), .empty(empty), .full(full),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_vec();
        int n;
        n = mq.size();
        return {m_num, m_valid, 4'(n), (n == 0), (n == DEPTH), m_drop, (n < DEPTH)};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {num, num_valid, count, empty, full, drop_err, in_ready};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_num    = 2'b00;
        m_valid  = 1'b0;
        m_drop   = 1'b0;
        hist     = '0;
        det_seen = 1'b0;
    endtask

    // Apply inputs for one cycle, advance the model on pre-edge state, and
    // return 1 ns after the edge.
    task automatic drive(input logic v, input logic [1:0] d, input logic r);
        int  n;
        logic rdy;
        in_valid  = v;
        in_num    = d;
        out_ready = r;
        @(posedge clk);
        n   = mq.size();
        rdy = (n < DEPTH);
        if (r && n > 0) begin
            m_num   = mq.pop_front();
            m_valid = 1'b1;
        end else begin
            m_num   = 2'b00;
            m_valid = 1'b0;
        end
        if (v && rdy)  mq.push_back(d);
        if (v && !rdy) m_drop = 1'b1;
        #1;
        hist = {hist[3:0], num};
        if (hist == 6'b01_10_11) det_seen = 1'b1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_num    = 2'b00;
        out_ready = 1'b0;
        reset     = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_num    = 2'b00;
        out_ready = 1'b1;
        reset     = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            obs = dut_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL reset_cycle%0d got=%b want=%b", i, obs, expv);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_seq123();
        logic [1:0] syms [3];
        syms[0] = 2'd1; syms[1] = 2'd2; syms[2] = 2'd3;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, syms[i], 1'b1);
            else       drive(1'b0, 2'b00, 1'b1);
            obs = dut_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL seq123_cycle%0d got=%b want=%b", i, obs, expv);
            end
        end
        checks++;
        if (det_seen !== 1'b1) begin
            failures++;
            $display("FAIL seq123_detect got=%b want=1", det_seen);
        end
        $display("test_seq123 done");
    endtask

    task automatic test_full_drop();
        logic [1:0] pat [8];
        logic [1:0] drained [$];
        pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd3; pat[3] = 2'd0;
        pat[4] = 2'd1; pat[5] = 2'd2; pat[6] = 2'd3; pat[7] = 2'd1;
        apply_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, pat[i], 1'b0);
        obs = dut_vec(); expv = exp_vec(); checks++;
        if (obs !== expv || full !== 1'b1 || count !== 4'd8 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_after8 got=%b want=%b", obs, expv);
        end
        drive(1'b1, 2'd2, 1'b0);
        checks++;
        if (drop_err !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL drop_ninth drop_err=%b count=%0d want drop_err=1 count=8", drop_err, count);
        end
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 2'b00, 1'b1);
            if (num_valid) drained.push_back(num);
            obs = dut_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL drain_cycle%0d got=%b want=%b", i, obs, expv);
            end
        end
        checks++;
        if (drained.size() != 8) begin
            failures++;
            $display("FAIL drain_len got=%0d want=8", drained.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (drained[i] !== pat[i]) begin
                    failures++;
                    $display("FAIL drain_order idx=%0d got=%0d want=%0d", i, drained[i], pat[i]);
                end
            end
        end
        checks++;
        if (empty !== 1'b1 || drop_err !== 1'b1) begin
            failures++;
            $display("FAIL drain_end empty=%b drop_err=%b want 1 1", empty, drop_err);
        end
        $display("test_full_drop done");
    endtask

    task automatic test_wrap_steady();
        apply_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 2'(i), 1'b0);
        for (int i = 7; i < 27; i++) begin
            drive(1'b1, 2'(i), 1'b1);
            obs = dut_vec(); expv = exp_vec(); checks++;
            if (obs !== expv || count !== 4'd7) begin
                failures++;
                $display("FAIL wrap_cycle%0d got=%b want=%b", i, obs, expv);
            end
        end
        $display("test_wrap_steady done");
    endtask

    task automatic test_gap();
        logic [1:0] want_num [4];
        logic       want_vld [4];
        want_num[0] = 2'd1; want_num[1] = 2'd0; want_num[2] = 2'd2; want_num[3] = 2'd3;
        want_vld[0] = 1'b1; want_vld[1] = 1'b0; want_vld[2] = 1'b1; want_vld[3] = 1'b1;
        apply_reset();
        drive(1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1)      drive(1'b1, 2'd2, 1'b1);
            else if (i == 2) drive(1'b1, 2'd3, 1'b1);
            else             drive(1'b0, 2'd0, 1'b1);
            obs = dut_vec(); expv = exp_vec(); checks++;
            if (obs !== expv || num !== want_num[i] || num_valid !== want_vld[i]) begin
                failures++;
                $display("FAIL gap_cycle%0d got=%b want=%b", i, obs, expv);
            end
        end
        checks++;
        if (det_seen !== 1'b0) begin
            failures++;
            $display("FAIL gap_detect got=%b want=0", det_seen);
        end
        $display("test_gap done");
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 2'(i + 1), 1'b0);
        drive(1'b0, 2'd0, 1'b1);
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        obs = dut_vec(); expv = exp_vec(); checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL midreset_async got=%b want=%b", obs, expv);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'd3, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        obs = dut_vec(); expv = exp_vec(); checks++;
        if (obs !== expv || num !== 2'd3) begin
            failures++;
            $display("FAIL midreset_push3 got=%b want=%b", obs, expv);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 99) < 45));
            obs = dut_vec(); expv = exp_vec(); checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL random_cycle%0d got=%b want=%b", i, obs, expv);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_num    = 2'b00;
        out_ready = 1'b0;
        model_clear();
        test_reset();
        test_seq123();
        test_full_drop();
        test_wrap_steady();
        test_gap();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
